// File: rtl/program_loader.sv
// program_loader -- writer side of the instruction-memory interface.
//
// Accepts a byte stream over a valid/ready handshake, assembles big-endian
// 32-bit words and writes them to instruction memory at byte addresses
// 0, 4, 8, ...  The processor is held in stall until loading completes.
// A load ends on the terminator word (never written) or after MAX_WORDS
// words, whichever comes first.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   start        begin a load (honoured only in IDLE or DONE)
//   byte_in      program byte, MSB of the word first
//   byte_valid   byte_in valid this cycle
//   byte_ready   loader accepts a byte this cycle
//   im_we        instruction-memory write strobe, one cycle per word
//   im_addr      byte address of the write (word index * 4)
//   im_wdata     assembled instruction word
//   cpu_hold     processor stall, high until DONE
//   done         load complete (level)
//   instr_count  words written in the last/current load
//   full         load ended by reaching MAX_WORDS
//
// State | meaning
// IDLE  | after reset, waiting for start, processor held
// RECV  | accepting bytes of the current word
// WRITE | one cycle; memory write (or terminator detected)
// DONE  | load finished, processor released, outputs held
//
// ADDR_W must be below 30 so that im_addr fits in 32 bits.

module program_loader #(
  parameter int          ADDR_W    = 8,
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] END_WORD  = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              im_we,
  output logic [31:0]       im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic [ADDR_W:0]   instr_count,
  output logic              full
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t          state;
  logic [1:0]      byte_cnt;
  logic [31:0]     shift;
  logic [31:0]     next_word;
  logic [ADDR_W:0] count_inc;
  logic            xfer;

  assign xfer      = byte_valid && byte_ready;
  assign next_word = {shift[23:0], byte_in};
  assign count_inc = instr_count + CNT_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      shift       <= '0;
      byte_ready  <= 1'b0;
      im_we       <= 1'b0;
      im_addr     <= '0;
      im_wdata    <= '0;
      cpu_hold    <= 1'b1;
      done        <= 1'b0;
      instr_count <= '0;
      full        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RECV;
            byte_ready  <= 1'b1;
            cpu_hold    <= 1'b1;
            done        <= 1'b0;
            instr_count <= '0;
            byte_cnt    <= '0;
            shift       <= '0;
            full        <= 1'b0;
          end
        end

        RECV: begin
          if (xfer) begin
            shift    <= next_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Decide write vs. terminator here so im_we is registered
              // and lands in the very next cycle.
              state      <= WRITE;
              byte_ready <= 1'b0;
              im_wdata   <= next_word;
              if (next_word != END_WORD) begin
                im_we   <= 1'b1;
                // instr_count < MAX_WORDS here, so the top bit is zero.
                im_addr <= 32'({instr_count, 2'b00});
              end
            end
          end
        end

        WRITE: begin
          im_we    <= 1'b0;
          byte_cnt <= '0;
          if (im_wdata == END_WORD) begin
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            full     <= 1'b0;
          end else begin
            instr_count <= count_inc;
            if (count_inc == MAX_CNT) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              full     <= 1'b1;
            end else begin
              state      <= RECV;
              byte_ready <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-memory interface.
- Accepts a byte stream (valid/ready handshake), assembles big-endian 32-bit instruction words, and writes them into instruction memory at consecutive byte addresses 0, 4, 8, and so on.
- Holds the processor in stall while loading.
- When loading ends, reports the instruction count that the processor's run length is taken from.

Parameters:
- ADDR_W, 8, word-index width; instruction memory holds 2**ADDR_W words.
- MAX_WORDS, 256, maximum words loaded before forced completion (must be <= 2**ADDR_W).
- END_WORD, 32'hFFFF_FFFF, terminator word; it is recognised but never written.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a load; sampled only in IDLE or DONE.
- byte_in  input  8  incoming program byte, MSB of the word first.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  instruction-memory write strobe, one cycle per word.
- im_addr  output  32  byte address of the write; equals word_idx*4, upper bits zero.
- im_wdata  output  32  assembled instruction word.
- cpu_hold  output  1  processor stall; high from reset until DONE.
- done  output  1  load complete; level signal held in DONE.
- instr_count  output  ADDR_W+1  number of words written in the last or current load.
- full  output  1  load ended by reaching MAX_WORDS rather than by END_WORD.

Behaviour:
- Reset: state IDLE. Outputs on reset:
  - byte_ready=0, im_we=0, im_addr=0, im_wdata=0
  - cpu_hold=1, done=0, instr_count=0, full=0
  - internal byte_cnt=0, shift register=0
- A byte transfer happens on a cycle where byte_valid && byte_ready. byte_in is ignored on all other cycles.
- States:
  - IDLE: byte_ready=0, cpu_hold=1. On start: go to RECV and clear instr_count, byte_cnt, and full.
  - RECV: byte_ready=1. Each transfer does shift = {shift[23:0], byte_in} and byte_cnt++. On the transfer that makes the 4th byte: go to WRITE next cycle, with the word latched into im_wdata.
  - WRITE (exactly one cycle): byte_ready=0.
    - If word == END_WORD: im_we=0, go to DONE, full=0.
    - Otherwise: im_we=1, im_addr=instr_count<<2, and instr_count increments at the end of the cycle.
    - If the incremented count == MAX_WORDS: go to DONE with full=1. Else return to RECV with byte_cnt=0.
  - DONE: done=1, cpu_hold=0, byte_ready=0. Outputs hold. start returns to RECV with the same clearing as IDLE; done and cpu_hold go back to 0/1 on the next cycle.
- Latency: im_we asserts in the cycle immediately after the 4th byte is accepted. Minimum throughput is 5 cycles per word.
- Gaps: byte_valid may drop at any time. A partial word is kept indefinitely; there is no timeout.
- start asserted in RECV or WRITE is ignored.
- reset mid-load: the partial word is discarded, no write is issued, and the loader returns to the reset state. Memory contents already written are not cleared.
- Simultaneous reset and start: reset wins.
- im_we is never asserted outside WRITE, and never for END_WORD.
- instr_count saturates at MAX_WORDS. im_addr never exceeds (MAX_WORDS-1)*4.

Test Plan:
- reset held 2 cycles -> cpu_hold=1, done=0, byte_ready=0, instr_count=0, im_we=0.
- start, then bytes 8C 01 00 04, then FF FF FF FF -> exactly one im_we pulse with im_addr=0 and im_wdata=32'h8C010004. Then done=1, cpu_hold=0, instr_count=1, full=0.
- Three words with byte_valid toggling every other cycle, then END_WORD -> writes at addresses 0, 4, 8 with correct data. No extra writes during gaps. instr_count=3.
- MAX_WORDS=4 (override), stream 4 non-terminator words -> 4th write at im_addr=12, then DONE with full=1, instr_count=4. Later bytes are not accepted (byte_ready=0).
- reset after 2 bytes of word 1 (word 0 already written) -> no im_we for the partial word. After start, the next word is written at im_addr=0 and instr_count restarts at 0.
- start pulsed in RECV mid-word -> ignored; the word completes normally. start in DONE -> new load begins, with done dropping and cpu_hold rising the next cycle.
